partial_share_sched: RTL and testbench

Scheduler that time-shares one extracted partial-circuit instance (a W-bit bitwise-OR datapath with lifted inputs and outputs) among NREQ requesters. It is placed between the requester-side logic and the partial instance produced by terminal-neighbour extraction. It arbitrates requests round-robin and drives the partial's operand ports from registers. It waits out the partial's configurable pipeline latency, then returns the result with the winning requester's ID over a valid/ready response channel.

---
 rtl/partial_share_sched.sv | 173 +++++++++++++++++
 tb/tb_partial_share_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/partial_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : partial_share_sched
// Purpose  : Round-robin time-sharing of one pipelined bitwise-OR partial
//            instance among NREQ requesters with a valid/ready response port.
//            Optional grant counter enabled by PARTIAL_SHARE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module partial_share_sched #(
    parameter int NREQ = 4,
    parameter int W    = 2,
    parameter int LAT  = 0,
    parameter int IDW  = 3
) (
    input  logic              CLK,
    input  logic              ASYNCRESET,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      part_a,
    output logic [W-1:0]      part_b,
    input  logic [W-1:0]      part_o,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_data,
    output logic              busy,
    output logic [15:0]       perf_grants
);

    localparam int             c_PW       = IDW + 1;
    localparam logic [IDW-1:0] c_LAST     = IDW'(NREQ - 1);
    localparam logic [1:0]     c_CNT_INIT = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_id_q;
    logic [1:0]     r_cnt;
    logic [W-1:0]   r_opa;
    logic [W-1:0]   r_opb;
    logic [W-1:0]   r_res;
    logic           r_resp_valid;
    logic           r_busy;

    logic           w_any;
    logic [IDW-1:0] w_grant;
    logic [W-1:0]   w_win_a;
    logic [W-1:0]   w_win_b;
    logic           w_accept;

    // Walk offsets from rr_ptr with explicit wrap so non-power-of-two NREQ works.
    always_comb begin : b_arb
        logic [c_PW-1:0] v_pos;
        w_any   = 1'b0;
        w_grant = '0;
        w_win_a = '0;
        w_win_b = '0;
        v_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_pos = {1'b0, r_rr_ptr} + c_PW'(k);
            if (v_pos > c_PW'(NREQ - 1)) begin
                v_pos = v_pos - c_PW'(NREQ);
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!w_any && req_valid[j] && (v_pos == c_PW'(j))) begin
                    w_any   = 1'b1;
                    w_grant = IDW'(j);
                    w_win_a = req_a[j*W +: W];
                    w_win_b = req_b[j*W +: W];
                end
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_any;

    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_accept && !ASYNCRESET && (w_grant == IDW'(j))) begin
                req_ready[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_id_q       <= '0;
            r_cnt        <= '0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_res        <= '0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_opa   <= w_win_a;
                        r_opb   <= w_win_b;
                        r_id_q  <= w_grant;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (LAT == 0) begin
                        r_res        <= part_o;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt   <= c_CNT_INIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_res        <= part_o;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_rr_ptr     <= (r_id_q == c_LAST) ? '0 : r_id_q + 1'b1;
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand registers only change on accept, so the partial sees no idle toggling.
    assign part_a     = r_opa;
    assign part_b     = r_opb;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_id_q;
    assign resp_data  = r_res;
    assign busy       = r_busy;

`ifdef PARTIAL_SHARE_PERF_EN
    logic [15:0] r_perf;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_perf <= '0;
        end else if (w_accept && (r_perf != 16'hFFFF)) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_grants = r_perf;
`else
    assign perf_grants = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_partial_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_partial_share_sched
// Purpose  : Vector-table and scoreboard bench for partial_share_sched with a
//            LAT=0 instance and a LAT=3 instance driving a pipelined OR model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_partial_share_sched;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int grants0  = 0;
    int grants3  = 0;

    // LAT=0 instance
    logic        rst0 = 1'b0;
    logic [3:0]  req_valid0 = '0, req_ready0;
    logic [7:0]  req_a0 = '0, req_b0 = '0;
    logic [1:0]  part_a0, part_b0, part_o0;
    logic        resp_valid0, resp_ready0 = 1'b0;
    logic [2:0]  resp_id0;
    logic [1:0]  resp_data0;
    logic        busy0;
    logic [15:0] perf0;

    assign part_o0 = part_a0 | part_b0;

    partial_share_sched #(.NREQ(4), .W(2), .LAT(0), .IDW(3)) u_dut0 (
        .CLK(CLK), .ASYNCRESET(rst0),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_a(req_a0), .req_b(req_b0),
        .part_a(part_a0), .part_b(part_b0), .part_o(part_o0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_id(resp_id0), .resp_data(resp_data0),
        .busy(busy0), .perf_grants(perf0)
    );

    // LAT=3 instance with a three-stage registered OR as the partial
    logic        rst3 = 1'b0;
    logic [3:0]  req_valid3 = '0, req_ready3;
    logic [7:0]  req_a3 = '0, req_b3 = '0;
    logic [1:0]  part_a3, part_b3, part_o3;
    logic        resp_valid3, resp_ready3 = 1'b0;
    logic [2:0]  resp_id3;
    logic [1:0]  resp_data3;
    logic        busy3;
    logic [15:0] perf3;
    logic [1:0]  pipe1 = '0, pipe2 = '0, pipe3 = '0;

    always @(posedge CLK) begin
        pipe1 <= part_a3 | part_b3;
        pipe2 <= pipe1;
        pipe3 <= pipe2;
    end
    assign part_o3 = pipe3;

    partial_share_sched #(.NREQ(4), .W(2), .LAT(3), .IDW(3)) u_dut3 (
        .CLK(CLK), .ASYNCRESET(rst3),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3),
        .part_a(part_a3), .part_b(part_b3), .part_o(part_o3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_id(resp_id3), .resp_data(resp_data3),
        .busy(busy3), .perf_grants(perf3)
    );

    typedef struct {
        logic [3:0] valid;
        logic [7:0] a;
        logic [7:0] b;
        int         hold;
        logic [2:0] exp_id;
        logic [1:0] exp_data;
    } vec_t;

    typedef struct {
        logic [2:0] id;
        logic [1:0] data;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic pop_cmp(input string tag, input logic [2:0] id, input logic [1:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_resp_id"}, 32'(id), 32'(e.id));
            check({tag, "_resp_data"}, 32'(data), 32'(e.data));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        req_valid0  = v.valid;
        req_a0      = v.a;
        req_b0      = v.b;
        resp_ready0 = (v.hold == 0);
        #1;
        check("req_ready", 32'(req_ready0), 32'(4'b0001 << v.exp_id));
        sb.push_back('{v.exp_id, v.exp_data});
        grants0++;
        @(posedge CLK); #1;
        check("issue_busy", 32'(busy0), 1);
        check("issue_ready", 32'(req_ready0), 0);
        check("issue_part_a", 32'(part_a0), 32'((v.a >> (2 * v.exp_id)) & 8'h03));
        lat = 0;
        while (!resp_valid0 && lat < 12) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("resp_latency", lat, 1);
        for (int i = 0; i < v.hold; i++) begin
            @(posedge CLK); #1;
            check("bp_valid", 32'(resp_valid0), 1);
            check("bp_id", 32'(resp_id0), 32'(v.exp_id));
            check("bp_data", 32'(resp_data0), 32'(v.exp_data));
            check("bp_busy_ready", {busy0, req_ready0}, 32'h10);
        end
        resp_ready0 = 1'b1;
        pop_cmp("dut0", resp_id0, resp_data0);
        @(posedge CLK); #1;
        check("back_idle", {resp_valid0, busy0}, 0);
    endtask

    task automatic run3(input logic [3:0] valid, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] exp_id, input logic [1:0] exp_data);
        int lat;
        req_valid3  = valid;
        req_a3      = a;
        req_b3      = b;
        resp_ready3 = 1'b1;
        #1;
        check("l3_req_ready", 32'(req_ready3), 32'(4'b0001 << exp_id));
        sb.push_back('{exp_id, exp_data});
        grants3++;
        @(posedge CLK); #1;
        req_valid3 = '0;
        lat = 0;
        while (!resp_valid3 && lat < 12) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("l3_resp_latency", lat, 4);
        pop_cmp("dut3", resp_id3, resp_data3);
        @(posedge CLK); #1;
        check("l3_back_idle", {resp_valid3, busy3}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs[0]  = '{4'b0100, 8'h10, 8'h20, 0, 3'd2, 2'b11};
        vecs[1]  = '{4'b1111, 8'hE4, 8'h00, 0, 3'd3, 2'b11};
        vecs[2]  = '{4'b1111, 8'hE4, 8'h00, 0, 3'd0, 2'b00};
        vecs[3]  = '{4'b1111, 8'hE4, 8'h00, 0, 3'd1, 2'b01};
        vecs[4]  = '{4'b1111, 8'hE4, 8'h00, 0, 3'd2, 2'b10};
        vecs[5]  = '{4'b1111, 8'hE4, 8'h00, 0, 3'd3, 2'b11};
        vecs[6]  = '{4'b1111, 8'hE4, 8'h00, 0, 3'd0, 2'b00};
        vecs[7]  = '{4'b0010, 8'h08, 8'h04, 5, 3'd1, 2'b11};
        vecs[8]  = '{4'b1001, 8'h42, 8'h00, 0, 3'd3, 2'b01};
        vecs[9]  = '{4'b1001, 8'h42, 8'h00, 0, 3'd0, 2'b10};
        vecs[10] = '{4'b0001, 8'h03, 8'h00, 0, 3'd0, 2'b11};
        vecs[11] = '{4'b1100, 8'h00, 8'h10, 0, 3'd2, 2'b01};

        // Reset with requests pending: nothing may be granted
        #1;
        rst0 = 1'b1;
        rst3 = 1'b1;
        req_valid0 = 4'hF;
        req_a0 = 8'hFF;
        req_b0 = 8'hFF;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_req_ready", 32'(req_ready0), 0);
        check("rst_resp_valid", 32'(resp_valid0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_part_ab", {part_a0, part_b0}, 0);
        check("rst_resp_id_data", {resp_id0, resp_data0}, 0);
        check("rst_perf", 32'(perf0), 0);
        req_valid0 = '0;
        @(negedge CLK);
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(posedge CLK); #1;
        check("idle_no_req", {busy0, req_ready0}, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

`ifdef PARTIAL_SHARE_PERF_EN
        check("perf_dut0", 32'(perf0), 32'(grants0));
`else
        check("perf_dut0", 32'(perf0), 0);
`endif

        // LAT=3: result must come from the delayed OR, not the live operands
        run3(4'b0001, 8'h00, 8'h01, 3'd0, 2'b01);

        // Reset while in WAIT drops the in-flight request from requester 1
        req_valid3 = 4'b0010;
        req_a3 = 8'h04;
        req_b3 = 8'h00;
        #1;
        check("l3_pre_abort_ready", 32'(req_ready3), 32'b0010);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("l3_wait_busy", 32'(busy3), 1);
        rst3 = 1'b1;
        #1;
        check("l3_rst_drop", {resp_valid3, busy3, req_ready3}, 0);
        check("l3_rst_part_a", 32'(part_a3), 0);
        req_valid3 = '0;
        #1;
        rst3 = 1'b0;
        grants3 = 0;
        seen = 0;
        repeat (8) begin
            @(posedge CLK); #1;
            if (resp_valid3) seen++;
        end
        check("l3_no_resp_after_rst", seen, 0);

        run3(4'b0011, 8'h09, 8'h00, 3'd0, 2'b01);
        run3(4'b1000, 8'hC0, 8'h00, 3'd3, 2'b11);

`ifdef PARTIAL_SHARE_PERF_EN
        check("perf_dut3", 32'(perf3), 32'(grants3));
`else
        check("perf_dut3", 32'(perf3), 0);
`endif
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
